// File: rtl/risc_datapath.sv
// Datapath for the 8-bit accumulator CPU: PC, IR, AC, ALU, address mux and write-data drive.
// The phase controller drives the strobes; opcode and is_zero feed back to it.
module risc_datapath #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              ld_ir,
    input  logic              inc_pc,
    input  logic              ld_pc,
    input  logic              ld_ac,
    input  logic              data_e,
    input  logic              halt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    output logic [OP_W-1:0]   opcode,
    output logic              is_zero,
    output logic              carry,
    output logic              halted
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(3'b010);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3'b011);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(3'b100);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(3'b101);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   sum;

    assign opcode       = ir[DATA_W-1 -: OP_W];
    assign mem_addr     = sel ? pc : ir[ADDR_W-1:0];
    assign is_zero      = (ac == '0);
    assign mem_wdata    = ac;
    assign mem_wdata_oe = data_e & ~halted;

    assign sum = {1'b0, ac} + {1'b0, mem_rdata};

    // HLT, SKZ, STO and JMP pass the accumulator through unchanged
    always_comb begin
        alu_res = ac;
        case (opcode)
            OP_ADD:  alu_res = sum[DATA_W-1:0];
            OP_AND:  alu_res = ac & mem_rdata;
            OP_XOR:  alu_res = ac ^ mem_rdata;
            OP_LDA:  alu_res = mem_rdata;
            default: alu_res = ac;
        endcase
    end

    // Strobes in the halt cycle still land; the freeze starts the cycle after
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            ir     <= '0;
            ac     <= '0;
            carry  <= 1'b0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (ld_ir)
                ir <= mem_rdata;
            if (ld_pc)
                pc <= ir[ADDR_W-1:0];
            else if (inc_pc)
                pc <= pc + ADDR_W'(1);
            if (ld_ac) begin
                ac <= alu_res;
                if (opcode == OP_ADD)
                    carry <= sum[DATA_W];
            end
            if (halt)
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_risc_datapath.sv
// Directed-vector bench for risc_datapath with hand-computed expectations.
module tb_risc_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_wdata_oe;
    logic [2:0] opcode;
    logic       is_zero, carry, halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    risc_datapath #(.DATA_W(8), .OP_W(3), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .ld_ir        (ld_ir),
        .inc_pc       (inc_pc),
        .ld_pc        (ld_pc),
        .ld_ac        (ld_ac),
        .data_e       (data_e),
        .halt         (halt),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wdata_oe (mem_wdata_oe),
        .opcode       (opcode),
        .is_zero      (is_zero),
        .carry        (carry),
        .halted       (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one set of strobes for exactly one rising edge, then drop them
    task automatic pulse(input logic i_ld_ir, input logic i_inc_pc, input logic i_ld_pc,
                         input logic i_ld_ac, input logic i_halt, input logic [7:0] rdata);
        mem_rdata = rdata;
        ld_ir     = i_ld_ir;
        inc_pc    = i_inc_pc;
        ld_pc     = i_ld_pc;
        ld_ac     = i_ld_ac;
        halt      = i_halt;
        @(posedge clk);
        #1;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        halt   = 1'b0;
        #1;
    endtask

    task automatic load_ir(input logic [7:0] v);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, v);
    endtask

    task automatic load_ac(input logic [7:0] v);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v);
    endtask

    initial begin
        rst = 1'b0;
        sel = 1'b1; ld_ir = 1'b0; inc_pc = 1'b0; ld_pc = 1'b0;
        ld_ac = 1'b0; data_e = 1'b0; halt = 1'b0; mem_rdata = 8'h00;
        #12;
        chk("rst_addr",   32'(mem_addr), 32'h00);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_zero",   32'(is_zero), 32'h1);
        chk("rst_wdata",  32'(mem_wdata), 32'h00);
        chk("rst_oe",     32'(mem_wdata_oe), 32'h0);
        chk("rst_carry",  32'(carry), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // fetch
        sel = 1'b1;
        load_ir(8'hA3);
        chk("fetch_addr_pc", 32'(mem_addr), 32'h00);
        chk("fetch_opcode",  32'(opcode), 32'h5);
        sel = 1'b0; #1;
        chk("fetch_operand", 32'(mem_addr), 32'h03);

        // ADD without carry, then carry and wrap
        load_ir(8'hA0);
        load_ac(8'h01);
        load_ir(8'h40);
        load_ac(8'h05);
        chk("add_nc_ac",    32'(mem_wdata), 32'h06);
        chk("add_nc_carry", 32'(carry), 32'h0);
        load_ir(8'hA0);
        load_ac(8'hF0);
        chk("lda_f0", 32'(mem_wdata), 32'hF0);
        load_ir(8'h40);
        load_ac(8'h20);
        chk("add_c_ac",    32'(mem_wdata), 32'h10);
        chk("add_c_carry", 32'(carry), 32'h1);
        chk("add_c_zero",  32'(is_zero), 32'h0);
        load_ac(8'hF0);
        chk("add_wrap_ac",    32'(mem_wdata), 32'h00);
        chk("add_wrap_carry", 32'(carry), 32'h1);
        chk("add_wrap_zero",  32'(is_zero), 32'h1);

        // PC load, wrap, priority, double increment
        sel = 1'b1;
        load_ir(8'hFF);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("pc_ld31", 32'(mem_addr), 32'h1F);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("pc_wrap", 32'(mem_addr), 32'h00);
        load_ir(8'hF2);
        pulse(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("pc_ld_prio", 32'(mem_addr), 32'h12);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("pc_skip2", 32'(mem_addr), 32'h14);

        // logic ops keep carry
        load_ir(8'hA0);
        load_ac(8'h5A);
        load_ir(8'h60);
        load_ac(8'h0F);
        chk("and_ac", 32'(mem_wdata), 32'h0A);
        load_ir(8'h80);
        load_ac(8'hFF);
        chk("xor_ac",    32'(mem_wdata), 32'hF5);
        chk("xor_carry", 32'(carry), 32'h1);

        // STO passes AC through and drives write data
        load_ir(8'hA0);
        load_ac(8'h3C);
        load_ir(8'hC0);
        load_ac(8'h99);
        chk("sto_ac_hold", 32'(mem_wdata), 32'h3C);
        data_e = 1'b1; #1;
        chk("sto_wdata", 32'(mem_wdata), 32'h3C);
        chk("sto_oe_on", 32'(mem_wdata_oe), 32'h1);
        data_e = 1'b0; #1;
        chk("sto_oe_off", 32'(mem_wdata_oe), 32'h0);

        // halt: same-cycle strobe lands, later strobes frozen
        load_ir(8'hA0);
        sel = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("halt_set",    32'(halted), 32'h1);
        chk("halt_inc_pc", 32'(mem_addr), 32'h15);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
        chk("frz_ac",     32'(mem_wdata), 32'h3C);
        chk("frz_pc",     32'(mem_addr), 32'h15);
        chk("frz_opcode", 32'(opcode), 32'h5);
        sel = 1'b0; #1;
        chk("frz_operand", 32'(mem_addr), 32'h00);
        data_e = 1'b1; #1;
        chk("frz_oe", 32'(mem_wdata_oe), 32'h0);
        chk("frz_carry", 32'(carry), 32'h1);
        data_e = 1'b0;

        // asynchronous reset mid-cycle
        sel = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_halted", 32'(halted), 32'h0);
        chk("arst_pc",     32'(mem_addr), 32'h00);
        chk("arst_ac",     32'(mem_wdata), 32'h00);
        chk("arst_opcode", 32'(opcode), 32'h0);
        chk("arst_carry",  32'(carry), 32'h0);
        chk("arst_zero",   32'(is_zero), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
